// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the wait-state memory controller: access sizes,
// read/write direction and FSM states.
package mem_ctrl_pkg;

  localparam logic [2:0] MS_BYTE  = 3'b000;
  localparam logic [2:0] MS_HALF  = 3'b001;
  localparam logic [2:0] MS_WORD  = 3'b010;
  localparam logic [2:0] MS_DWORD = 3'b011;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StWait,
    StBeat,
    StHold
  } state_e;

  // Total bytes touched by an access of the given size (doubleword = 8)
  function automatic logic [3:0] ms_bytes(input logic [2:0] ms);
    unique case (ms)
      MS_HALF:  ms_bytes = 4'd2;
      MS_WORD:  ms_bytes = 4'd4;
      MS_DWORD: ms_bytes = 4'd8;
      default:  ms_bytes = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-wide storage with a 4-byte combinational read window and per-byte
// write enables. Lane i maps to address offset i; offsets wrap at depth.
module mem_byte_array #(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 CLK,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [31:0]          rdata,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [3:0]           we,
  input  logic [31:0]          wdata
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;

  // No reset: contents survive controller reset
  logic [7:0] mem [Depth];

  // Commit enabled byte lanes
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[ADDR_BITS'(wr_addr + ADDR_BITS'(i))] <= wdata[8*i +: 8];
    end
  end

  // Four consecutive bytes starting at rd_addr
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rdata[8*i +: 8] = mem[ADDR_BITS'(rd_addr + ADDR_BITS'(i))];
    end
  end

endmodule

// File: rtl/mem_wait_ctrl.sv
// MOV/MOC memory controller: latches a request, rejects illegal accesses
// with ABORT, inserts wait states, steers bytes and sign-extends loads.
module mem_wait_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned WAIT_STATES = 2,
  parameter bit          BIG_ENDIAN  = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MOV,
  input  logic        RW,
  input  logic [2:0]  MS,
  input  logic        SX,
  input  logic [31:0] ADDR,
  input  logic [31:0] DATA_IN,
  output logic [31:0] DATA_OUT,
  output logic        MOC,
  output logic        ABORT,
  output logic        BEAT2,
  output logic        BUSY
);

  localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [2:0]  ms_q, ms_d;
  logic        sx_q, sx_d;
  logic        beat2_q, beat2_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] data_out_q, data_out_d;

  logic        reject;
  logic [32:0] last_byte;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] rd_val;

  mem_byte_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_mem (
    .CLK    (CLK),
    .rd_addr(addr_d[ADDR_BITS-1:0]),
    .rdata  (rdata),
    .wr_addr(addr_q[ADDR_BITS-1:0]),
    .we     (we),
    .wdata  (wdata)
  );

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Latched request, beat tracking, wait counter and read data
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      addr_q     <= '0;
      rw_q       <= RW_READ;
      ms_q       <= MS_BYTE;
      sx_q       <= 1'b0;
      beat2_q    <= 1'b0;
      cnt_q      <= '0;
      data_out_q <= '0;
    end else begin
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      ms_q       <= ms_d;
      sx_q       <= sx_d;
      beat2_q    <= beat2_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
    end
  end

  // Rejection rule on the latched request; the end-address overflow also
  // catches any nonzero address bit above ADDR_BITS
  always_comb begin
    last_byte = {1'b0, addr_q} + {29'd0, ms_bytes(ms_q)} - 33'd1;
    reject    = 1'b0;
    if (ms_q[2]) begin
      reject = 1'b1;
    end else begin
      if (ms_q == MS_HALF && addr_q[0]) reject = 1'b1;
      if ((ms_q == MS_WORD || ms_q == MS_DWORD) && addr_q[1:0] != 2'b00) reject = 1'b1;
      if ((last_byte >> ADDR_BITS) != 33'd0) reject = 1'b1;
    end
  end

  // Next-state and request bookkeeping
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    ms_d    = ms_q;
    sx_d    = sx_q;
    beat2_d = beat2_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (MOV) begin
          state_d = StCheck;
          addr_d  = ADDR;
          rw_d    = RW;
          ms_d    = MS;
          sx_d    = SX;
          beat2_d = 1'b0;
          cnt_d   = '0;
        end
      end
      StCheck: begin
        if (reject) begin
          state_d = StHold;
        end else if (WAIT_STATES == 0) begin
          state_d = StBeat;
        end else begin
          state_d = StWait;
          cnt_d   = WaitLoad;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = StBeat;
          cnt_d   = '0;
        end
      end
      StBeat: begin
        if (ms_q == MS_DWORD && !beat2_q) begin
          if (MOV) begin
            addr_d  = addr_q + 32'd4;
            beat2_d = 1'b1;
            if (WAIT_STATES == 0) begin
              state_d = StBeat;
            end else begin
              state_d = StWait;
              cnt_d   = WaitLoad;
            end
          end else begin
            // Requester gave up after the first beat
            state_d = StIdle;
          end
        end else begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (!MOV) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Write byte steering; enables only asserted on a write beat
  always_comb begin
    we    = '0;
    wdata = '0;
    unique case (ms_q)
      MS_BYTE: begin
        we          = 4'b0001;
        wdata[7:0]  = DATA_IN[7:0];
      end
      MS_HALF: begin
        we          = 4'b0011;
        wdata[15:0] = BIG_ENDIAN ? {DATA_IN[7:0], DATA_IN[15:8]} : DATA_IN[15:0];
      end
      MS_WORD, MS_DWORD: begin
        we    = 4'b1111;
        wdata = BIG_ENDIAN ? {DATA_IN[7:0], DATA_IN[15:8], DATA_IN[23:16], DATA_IN[31:24]}
                           : DATA_IN;
      end
      default: ;
    endcase
    if (!(state_q == StBeat && rw_q == RW_WRITE)) we = '0;
  end

  // Read assembly; DATA_OUT loads on entry to a read beat so it is valid
  // in the same cycle as MOC
  always_comb begin
    rd_val = '0;
    unique case (ms_q)
      MS_BYTE: rd_val = {{24{sx_q & rdata[7]}}, rdata[7:0]};
      MS_HALF: begin
        rd_val[15:0]  = BIG_ENDIAN ? {rdata[7:0], rdata[15:8]} : rdata[15:0];
        rd_val[31:16] = {16{sx_q & rd_val[15]}};
      end
      MS_WORD, MS_DWORD: begin
        rd_val = BIG_ENDIAN ? {rdata[7:0], rdata[15:8], rdata[23:16], rdata[31:24]} : rdata;
      end
      default: ;
    endcase
    data_out_d = data_out_q;
    if (state_d == StBeat && rw_q == RW_READ && state_q != StIdle) data_out_d = rd_val;
  end

  // Handshake outputs decoded from state
  always_comb begin
    MOC      = (state_q == StBeat);
    ABORT    = (state_q == StCheck) && reject;
    BEAT2    = (state_q == StBeat) && beat2_q;
    BUSY     = (state_q != StIdle);
    DATA_OUT = data_out_q;
  end

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Directed bench for mem_wait_ctrl: a driver issues requests and queues the
// expected responses; a monitor pops and compares on every MOC/ABORT.
module tb_mem_wait_ctrl;
  import mem_ctrl_pkg::*;

  localparam int unsigned AB = 8;
  localparam int          WS = 2;
  localparam bit          BE = 1'b1;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        MOV = 1'b0;
  logic        RW = 1'b1;
  logic [2:0]  MS = 3'b000;
  logic        SX = 1'b0;
  logic [31:0] ADDR = '0;
  logic [31:0] DATA_IN = '0;
  logic [31:0] DATA_OUT;
  logic        MOC;
  logic        ABORT;
  logic        BEAT2;
  logic        BUSY;

  mem_wait_ctrl #(
    .ADDR_BITS  (AB),
    .WAIT_STATES(WS),
    .BIG_ENDIAN (BE)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .MOV     (MOV),
    .RW      (RW),
    .MS      (MS),
    .SX      (SX),
    .ADDR    (ADDR),
    .DATA_IN (DATA_IN),
    .DATA_OUT(DATA_OUT),
    .MOC     (MOC),
    .ABORT   (ABORT),
    .BEAT2   (BEAT2),
    .BUSY    (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_abort;
    int          cyc;
    logic [31:0] data;
    bit          beat2;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] last_rd = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: every MOC/ABORT must match the head of the scoreboard
  always @(negedge CLK) begin
    if (RESET && (MOC || ABORT)) begin
      n_checks++;
      if (MOC && ABORT) begin
        n_errors++;
        $display("FAIL moc_abort_excl: got MOC=1 ABORT=1 at cyc %0d, expected one of them", cyc);
      end else if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_resp: got MOC=%0b ABORT=%0b at cyc %0d, expected none",
                 MOC, ABORT, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.is_abort != ABORT || mon_e.cyc != cyc || mon_e.data !== DATA_OUT ||
            mon_e.beat2 != BEAT2) begin
          n_errors++;
          $display("FAIL resp: got abort=%0b cyc=%0d data=%h beat2=%0b, expected abort=%0b cyc=%0d data=%h beat2=%0b",
                   ABORT, cyc, DATA_OUT, BEAT2, mon_e.is_abort, mon_e.cyc, mon_e.data,
                   mon_e.beat2);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One request: queue expectations, scramble inputs after latch, wait for
  // the final response, optionally hold MOV, then check BUSY release
  task automatic do_access(input logic rw, input logic [2:0] ms, input logic sx,
                           input logic [31:0] addr, input logic [31:0] d0,
                           input logic [31:0] d1, input bit abort_exp,
                           input logic [31:0] r0, input logic [31:0] r1,
                           input int hold_extra);
    int   k;
    exp_t e;
    @(posedge CLK); #1;
    k       = cyc + 1;
    MOV     = 1'b1;
    RW      = rw;
    MS      = ms;
    SX      = sx;
    ADDR    = addr;
    DATA_IN = d0;
    if (abort_exp) begin
      e.is_abort = 1'b1; e.cyc = k; e.data = last_rd; e.beat2 = 1'b0;
      sb_q.push_back(e);
    end else begin
      if (rw == RW_READ) last_rd = r0;
      e.is_abort = 1'b0; e.cyc = k + 1 + WS; e.data = last_rd; e.beat2 = 1'b0;
      sb_q.push_back(e);
      if (ms == MS_DWORD) begin
        if (rw == RW_READ) last_rd = r1;
        e.cyc = k + 2 + 2 * WS; e.data = last_rd; e.beat2 = 1'b1;
        sb_q.push_back(e);
      end
    end
    @(posedge CLK); #1;
    RW   = ~rw;
    MS   = 3'b111;
    SX   = ~sx;
    ADDR = ~addr;
    for (int i = 0; i < 64 && sb_q.size() != 0; i++) begin
      if (ms == MS_DWORD && sb_q.size() == 1) DATA_IN = d1;
      @(posedge CLK); #1;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: got %0d responses outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
    repeat (hold_extra) begin
      @(posedge CLK); #1;
    end
    MOV = 1'b0;
    @(negedge CLK);
    check("busy_hold", {63'd0, BUSY}, 64'd1);
    @(negedge CLK);
    check("busy_idle", {63'd0, BUSY}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    dut.u_mem.mem[0]   = 8'h12; dut.u_mem.mem[1]   = 8'h34;
    dut.u_mem.mem[2]   = 8'h56; dut.u_mem.mem[3]   = 8'h78;
    dut.u_mem.mem[4]   = 8'hA0; dut.u_mem.mem[5]   = 8'hA1;
    dut.u_mem.mem[6]   = 8'hA2; dut.u_mem.mem[7]   = 8'hA3;
    dut.u_mem.mem[16]  = 8'h01; dut.u_mem.mem[17]  = 8'h02;
    dut.u_mem.mem[18]  = 8'h03; dut.u_mem.mem[19]  = 8'h04;
    dut.u_mem.mem[252] = 8'hC0; dut.u_mem.mem[253] = 8'hC1;
    dut.u_mem.mem[254] = 8'hC2; dut.u_mem.mem[255] = 8'hC3;

    repeat (3) @(posedge CLK);
    #1;
    check("reset_outputs", {27'd0, DATA_OUT, MOC, ABORT, BEAT2, BUSY}, 64'd0);
    RESET = 1'b1;

    // Word read, sub-word writes and sign-extending byte reads
    do_access(RW_READ,  MS_WORD, 1'b0, 32'h0, '0, '0, 1'b0, 32'h12345678, '0, 0);
    do_access(RW_WRITE, MS_BYTE, 1'b0, 32'h2, 32'hFFFFFF96, '0, 1'b0, '0, '0, 0);
    do_access(RW_WRITE, MS_BYTE, 1'b0, 32'h3, 32'h1234565A, '0, 1'b0, '0, '0, 0);
    do_access(RW_READ,  MS_BYTE, 1'b1, 32'h2, '0, '0, 1'b0, 32'hFFFFFF96, '0, 0);
    do_access(RW_READ,  MS_BYTE, 1'b0, 32'h2, '0, '0, 1'b0, 32'h00000096, '0, 0);
    do_access(RW_READ,  MS_BYTE, 1'b1, 32'h3, '0, '0, 1'b0, 32'h0000005A, '0, 0);
    do_access(RW_READ,  MS_WORD, 1'b0, 32'h0, '0, '0, 1'b0, 32'h1234965A, '0, 0);

    // Halfword write touches only its two bytes
    do_access(RW_WRITE, MS_HALF, 1'b0, 32'h6, 32'hAAAABEEF, '0, 1'b0, '0, '0, 0);
    do_access(RW_READ,  MS_WORD, 1'b0, 32'h4, '0, '0, 1'b0, 32'hA0A1BEEF, '0, 0);
    do_access(RW_READ,  MS_HALF, 1'b1, 32'h6, '0, '0, 1'b0, 32'hFFFFBEEF, '0, 0);
    do_access(RW_READ,  MS_HALF, 1'b0, 32'h4, '0, '0, 1'b0, 32'h0000A0A1, '0, 0);

    // Rejections, then proof that the rejected write changed nothing
    do_access(RW_READ,  MS_HALF,  1'b0, 32'h1,   '0, '0, 1'b1, '0, '0, 0);
    do_access(RW_READ,  MS_WORD,  1'b0, 32'h100, '0, '0, 1'b1, '0, '0, 0);
    do_access(RW_READ,  3'b100,   1'b0, 32'h0,   '0, '0, 1'b1, '0, '0, 0);
    do_access(RW_READ,  MS_WORD,  1'b0, 32'h2,   '0, '0, 1'b1, '0, '0, 0);
    do_access(RW_READ,  MS_DWORD, 1'b0, 32'hFC,  '0, '0, 1'b1, '0, '0, 0);
    do_access(RW_WRITE, MS_HALF,  1'b0, 32'h1, 32'h0000FFFF, '0, 1'b1, '0, '0, 0);
    do_access(RW_READ,  MS_WORD,  1'b0, 32'h0,   '0, '0, 1'b0, 32'h1234965A, '0, 0);
    do_access(RW_READ,  MS_WORD,  1'b0, 32'hFC,  '0, '0, 1'b0, 32'hC0C1C2C3, '0, 0);
    do_access(RW_READ,  MS_BYTE,  1'b0, 32'hFF,  '0, '0, 1'b0, 32'h000000C3, '0, 0);

    // Doubleword transfers; the read holds MOV past the final MOC
    do_access(RW_WRITE, MS_DWORD, 1'b0, 32'h8, 32'h11223344, 32'h55667788, 1'b0, '0, '0, 0);
    do_access(RW_READ,  MS_DWORD, 1'b0, 32'h8, '0, '0, 1'b0, 32'h11223344, 32'h55667788, 5);
    do_access(RW_READ,  MS_BYTE,  1'b0, 32'h9,  '0, '0, 1'b0, 32'h00000022, '0, 0);
    do_access(RW_READ,  MS_BYTE,  1'b1, 32'hF,  '0, '0, 1'b0, 32'hFFFFFF88, '0, 0);
    do_access(RW_READ,  MS_WORD,  1'b0, 32'hC,  '0, '0, 1'b0, 32'h55667788, '0, 0);

    // Reset during the wait of a word write abandons it
    @(posedge CLK); #1;
    MOV = 1'b1; RW = RW_WRITE; MS = MS_WORD; SX = 1'b0; ADDR = 32'h10; DATA_IN = 32'hCAFEF00D;
    @(posedge CLK);
    @(posedge CLK); #1;
    RESET = 1'b0;
    #1;
    check("reset_mid_op", {27'd0, DATA_OUT, MOC, ABORT, BEAT2, BUSY}, 64'd0);
    MOV     = 1'b0;
    last_rd = '0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    do_access(RW_READ, MS_WORD, 1'b0, 32'h10, '0, '0, 1'b0, 32'h01020304, '0, 0);

    repeat (3) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_wait_ctrl.md
# mem_wait_ctrl

Parametrised byte-addressable main memory with MOV/MOC handshake for the ARM datapath. It is the successor to the fixed 256-byte RAM. It adds:
- configurable depth and wait states;
- doubleword two-beat transfers;
- sign-extending sub-word loads;
- an ABORT response for misaligned, out-of-range or reserved accesses.

The control unit drives MOV/RW/MS from its microword; MAR feeds ADDR, MDR feeds DATA_IN, and DATA_OUT feeds IR/MDR.

## Interface
- ADDR_BITS, 8, byte address width; depth = 2^ADDR_BITS bytes
- WAIT_STATES, 2, extra cycles before each beat completes (0..15)
- BIG_ENDIAN, 1, 1 = byte at lowest address is MSB of word; 0 = little-endian

- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- MOV  in  1  memory operation valid; held high by requester until final MOC/ABORT
- RW  in  1  1 = read, 0 = write
- MS  in  3  size: 000 byte, 001 halfword, 010 word, 011 doubleword; 1xx reserved
- SX  in  1  sign-extend byte/halfword reads (ignored otherwise)
- ADDR  in  32  byte address
- DATA_IN  in  32  write data; low bits used for sub-word writes
- DATA_OUT  out  32  read data, registered
- MOC  out  1  one-cycle pulse per completed beat
- ABORT  out  1  one-cycle pulse, access rejected, no state change in memory
- BEAT2  out  1  high with MOC on the second doubleword beat
- BUSY  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, CHECK, WAIT, BEAT, HOLD.
- IDLE: MOV=1 sampled → latch ADDR/RW/MS/SX, go to CHECK.
- CHECK: the rejection rule is evaluated on latched values. An access is rejected if:
  - MS is reserved;
  - it is misaligned: halfword needs addr[0]=0; word and doubleword need addr[1:0]=0;
  - ADDR bits above ADDR_BITS are nonzero;
  - the last byte (addr+size−1; doubleword size 8) exceeds the depth.
  - Reject → ABORT pulse, go to HOLD. Accept → WAIT, counter = WAIT_STATES.
- WAIT: decrement each cycle; at 0 go to BEAT (WAIT_STATES=0 passes through in one cycle).
- BEAT: perform the access; MOC=1 this cycle.
  - Read: DATA_OUT ← assembled data.
  - Write: bytes committed at the edge ending BEAT.
  - Non-doubleword → HOLD.
  - Doubleword first beat: address += 4, MOV still 1 → WAIT with counter reloaded; MOV=0 → IDLE, second beat dropped.
  - Doubleword second beat: BEAT2=1, DATA_IN sampled again for writes → HOLD.
- HOLD: stay until MOV=0, then IDLE. This prevents retrigger on a held MOV.
- Sub-word read: byte/halfword right-justified, upper bits zero or sign-filled per SX.
- Sub-word write: only the addressed bytes change.
- Byte order follows BIG_ENDIAN. Example: halfword at a, big-endian: mem[a] = D[15:8], mem[a+1] = D[7:0].
- DATA_OUT changes only on read beats and otherwise holds its value; writes do not alter it.
- RW/MS/ADDR changes after latching are ignored until IDLE.

## Timing
- Reset (RESET=0, asynchronous): state IDLE, DATA_OUT=0, MOC=ABORT=BEAT2=BUSY=0, wait counter 0.
- Memory contents are not cleared by reset.
- Reset mid-operation abandons the access. A write not yet at its BEAT edge commits nothing.
- MOV sampled at edge k: BUSY high from k+1.
  - Reject: ABORT high during cycle k+1.
  - Accept: MOC high during cycle k+2+WAIT_STATES.
- Doubleword second MOC: WAIT_STATES+1 cycles after the first MOC.
- DATA_OUT valid in the same cycle as MOC and stable until the next read beat.
- MOC and ABORT are never high together. BUSY drops the cycle after MOV=0 is seen in HOLD.

## Structure
- Package mem_ctrl_pkg holds:
  - MS encodings (MS_BYTE, MS_HALF, MS_WORD, MS_DWORD);
  - state encodings;
  - RW_READ/RW_WRITE constants.
- Sub-module mem_byte_array: 2^ADDR_BITS × 8 storage, 4-byte read port, per-byte write enables.
  - Array named mem so benches preload it hierarchically from a file.
- Top level holds the FSM, wait counter, alignment/range check, byte steering and sign extension.

## Test plan
1. WAIT_STATES=2, preload mem[0..3] = 12 34 56 78; word read at 0 → MOC in cycle k+4, DATA_OUT = 0x12345678 (BIG_ENDIAN=1).
2. Byte read at 2, then at 3, with mem[2..3] = 0x96, 0x5A:
   - at 2, SX=1 → 0xFFFFFF96; SX=0 → 0x00000096;
   - at 3, SX=1 → 0x0000005A.
3. Halfword write of 0xAAAABEEF at 6, then word read at 4 → bytes 6–7 = BE EF, bytes 4–5 unchanged.
4. Halfword read at 1 → ABORT at k+1, no MOC, memory unchanged. Word read at 0x100 with ADDR_BITS=8 → ABORT.
5. Doubleword write at 8 (0x11111111, then 0x22222222); doubleword read at 8 → two MOCs WAIT_STATES+1 apart, second with BEAT2=1, values match.
6. Reset asserted during WAIT of a write → outputs 0 immediately, target bytes unchanged. MOV held high after MOC → no second access until MOV drops.
